mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised modulo counter, successor to the team's fixed mod-N up counter. Counts up or down over a run-time programmable range 0..`limit`, supports synchronous load, and provides terminal-count, cascade-carry and registered wrap outputs. Used as the general timebase/event-counter primitive in lab designs. Multiple instances can be chained through `carry_out` → `ce`.

## Interface
Parameters:
- `WIDTH`, 8: counter width in bits; legal range 2..32.
- `RESET_VAL`, 0: value of `q` after reset; must be ≤ the `limit` in use at reset.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ce` in 1: count enable; one step per cycle while high.
- `up` in 1: direction; 1 = increment, 0 = decrement. Sampled every cycle.
- `load` in 1: synchronous load strobe.
- `load_val` in WIDTH: value loaded on `load`.
- `limit` in WIDTH: terminal value; count range is 0..`limit` inclusive, `limit`+1 states.
- `q` out WIDTH: current count, registered.
- `tc` out 1: terminal count, combinational from `q`/`up`/`limit`.
- `carry_out` out 1: `tc & ce_eff`, combinational, for cascading.
- `wrap` out 1: registered one-cycle pulse, high in the cycle after a wrap step.

## Operation
- Priority per edge: `rst` > `load` > `ce_eff` > hold.
- `rst`: `q` ← `RESET_VAL`, `wrap` ← 0. Prescaler state cleared if compiled in.
- `load`: `q` ← min(`load_val`, `limit`). `wrap` ← 0. Overrides `ce`.
- Count step, up: if `q` ≥ `limit` then `q` ← 0, `wrap` ← 1; else `q` ← `q`+1.
- Count step, down: if `q` == 0 then `q` ← `limit`, `wrap` ← 1; else `q` ← `q`−1.
- Hold (no rst/load/`ce_eff`): `q` unchanged, `wrap` ← 0.
- `tc` = `up` ? (`q` ≥ `limit`) : (`q` == 0).
- `ce_eff` = `ce` without prescaler. With prescaler: `ce` AND prescaler tick (see Configuration).
- Arithmetic is WIDTH-bit unsigned. No modular overflow is possible because wrap is explicit. The comparison `q` ≥ `limit` is unsigned.
- `limit` changed below current `q`: the next up step wraps to 0 with `wrap`=1; a down step decrements normally.
- `limit` = 0: `q` is held at 0. Every up or down step sets `wrap`=1, so `tc`=1 constantly.
- Changing `up` mid-count takes effect on the same edge; there is no pipeline.

## Timing
- `q` latency: 1 cycle from the `ce`/`load`/`rst` sample edge.
- `wrap` is asserted in the same cycle that `q` shows the wrapped value (0 or `limit`) and lasts exactly one cycle per wrap step. Consecutive wrap steps (`limit`=0) keep it high continuously.
- `tc` and `carry_out` have zero latency (combinational). The downstream stage steps on the same edge as this counter wraps.
- Reset values: `q`=`RESET_VAL`, `wrap`=0. `tc` follows from `q`, so it is 1 if `RESET_VAL`==0 and `up`=0.
- `rst` asserted mid-count takes effect at the next edge regardless of `ce`/`load`.

## Configuration
- Macro `MOD_COUNTER_PRESCALER_EN`.
- Defined:
  - Adds parameter `PRESC` (default 4, ≥1) and an internal modulo-`PRESC` prescaler counting `ce` cycles.
  - `ce_eff` is high only on the `ce` cycle where the prescaler is at `PRESC`−1; the prescaler then returns to 0.
  - `load` does not affect the prescaler; `rst` clears it.
  - `PRESC`=1 behaves identically to the undefined build.
- Undefined: no prescaler logic, `ce_eff` = `ce`, and the `PRESC` parameter is absent.

## Test plan
- Reset/up count: WIDTH=8, `limit`=5, `up`=1, `ce`=1 for 14 cycles after `rst` → `q` 0,1,2,3,4,5,0,1,…; `wrap` high on each return to 0; `tc` high while `q`=5.
- Down count: `limit`=3, `up`=0, start `q`=0 → `q` 3,2,1,0,3; `wrap` on each 3 after a 0; `carry_out`=1 only while `q`=0 and `ce`=1.
- Load priority/clamp: `load`=1, `ce`=1, `load_val`=9, `limit`=6 → `q`=6, `wrap`=0; then `load_val`=2 → `q`=2.
- Limit shrink / limit 0: `q`=7, set `limit`=4, step up → `q`=0, `wrap`=1. Set `limit`=0 with `ce`=1 for 3 cycles → `q`=0 and `wrap`=1 on all 3 cycles.
- Reset mid-operation: `RESET_VAL`=2, `rst` with `load`=1, `ce`=1 → `q`=2, `wrap`=0; `ce` low for 5 cycles → `q` held.
- Prescaler (macro defined, `PRESC`=3): `ce`=1 continuously, `limit`=2 → `q` increments every 3rd cycle; `wrap` after 9 `ce` cycles.

Source files
------------

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: up/down modulo counter with a run-time range 0..limit.
// Features: synchronous load (clamped to limit), terminal count, cascade carry
// and a registered wrap pulse.
// Optional prescaler: define MOD_COUNTER_PRESCALER_EN to add parameter PRESC.
// With the prescaler, only every PRESC-th ce cycle advances the count.
module mod_updown_counter #(
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 0
`ifdef MOD_COUNTER_PRESCALER_EN
  ,
  parameter int PRESC     = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             carry_out,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             ce_eff;

`ifdef MOD_COUNTER_PRESCALER_EN
  // Keep the prescaler at least one bit wide so PRESC=1 still elaborates.
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic          presc_tick;

  // Prescaler counts ce cycles modulo PRESC; load leaves it alone.
  always_comb begin
    presc_tick = (presc_q == PW'(PRESC - 1));
    presc_d    = presc_q;
    if (ce) begin
      presc_d = presc_tick ? '0 : presc_q + PW'(1);
    end
    ce_eff = ce & presc_tick;
  end

  // Prescaler register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  // Without the prescaler every ce cycle is a counting cycle.
  always_comb begin
    ce_eff = ce;
  end
`endif

  // Terminal count depends on direction: limit (or above) going up, 0 going down.
  always_comb begin
    tc        = up ? (cnt_q >= limit) : (cnt_q == '0);
    carry_out = tc & ce_eff;
  end

  // Next count: load beats counting; a wrap step raises the wrap flag.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = (load_val > limit) ? limit : load_val;
    end else if (ce_eff) begin
      if (up) begin
        if (cnt_q >= limit) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d  = limit;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  // Count and wrap registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= WIDTH'(RESET_VAL);
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = cnt_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Testbench for mod_updown_counter: directed steps followed by a random run.
// Each step is checked against a behavioural model kept here.
module tb_mod_updown_counter;

  localparam int W  = 8;
  localparam int RV = 2;
`ifdef MOD_COUNTER_PRESCALER_EN
  localparam int PRESC = 3;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ce = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] q;
  logic         tc, carry_out, wrap;

  int total = 0;
  int bad   = 0;

  // Model state: count value, wrap flag and prescaler phase as plain integers.
  int mq    = 0;
  int mwrap = 0;
  int mpre  = 0;

`ifdef MOD_COUNTER_PRESCALER_EN
  mod_updown_counter #(.WIDTH(W), .RESET_VAL(RV), .PRESC(PRESC)) dut (
`else
  mod_updown_counter #(.WIDTH(W), .RESET_VAL(RV)) dut (
`endif
    .clk(clk), .rst(rst), .ce(ce), .up(up), .load(load),
    .load_val(load_val), .limit(limit), .q(q), .tc(tc),
    .carry_out(carry_out), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; check the combinational outputs before the edge,
  // then advance the model and check the registered outputs after it.
  task automatic applyStimulus(input string tag, input logic r, input logic c, input logic u,
                               input logic l, input int lv, input int lim);
    int ceEff;
    int expTc;
    @(negedge clk);
    rst = r; ce = c; up = u; load = l;
    load_val = W'(lv); limit = W'(lim);
    #1;
`ifdef MOD_COUNTER_PRESCALER_EN
    ceEff = (c && mpre == PRESC - 1) ? 1 : 0;
`else
    ceEff = c ? 1 : 0;
`endif
    expTc = u ? ((mq >= lim) ? 1 : 0) : ((mq == 0) ? 1 : 0);
    checkOutput({tag, ".tc"}, {31'd0, tc}, expTc);
    checkOutput({tag, ".carry"}, {31'd0, carry_out}, expTc & ceEff);
    @(posedge clk);
    if (r) begin
      mq = RV; mwrap = 0; mpre = 0;
    end else begin
`ifdef MOD_COUNTER_PRESCALER_EN
      if (c) mpre = (mpre + 1) % PRESC;
`endif
      mwrap = 0;
      if (l) begin
        mq = (lv < lim) ? lv : lim;
      end else if (ceEff != 0) begin
        if (u) begin
          if (mq >= lim) begin mq = 0; mwrap = 1; end
          else mq = mq + 1;
        end else begin
          if (mq == 0) begin mq = lim; mwrap = 1; end
          else mq = mq - 1;
        end
      end
    end
    #1;
    checkOutput({tag, ".q"}, {24'd0, q}, mq);
    checkOutput({tag, ".wrap"}, {31'd0, wrap}, mwrap);
  endtask

  initial begin
    // Reset, then load 0 and count up through limit 5 several times.
    applyStimulus("reset", 1, 0, 1, 0, 0, 5);
    applyStimulus("ld0", 0, 0, 1, 1, 0, 5);
    for (int i = 0; i < 14; i++) applyStimulus("upcnt", 0, 1, 1, 0, 0, 5);

    // Count down over limit 3 starting from 0.
    applyStimulus("ld0b", 0, 0, 0, 1, 0, 3);
    for (int i = 0; i < 6; i++) applyStimulus("dncnt", 0, 1, 0, 0, 0, 3);
    applyStimulus("dnhold", 0, 0, 0, 0, 0, 3);

    // Load overrides ce and clamps to limit.
    applyStimulus("ldclamp", 0, 1, 1, 1, 9, 6);
    applyStimulus("ld2", 0, 1, 1, 1, 2, 6);

    // Shrink limit below q, then run with limit 0.
    applyStimulus("ld7", 0, 0, 1, 1, 7, 10);
    for (int i = 0; i < 3; i++) applyStimulus("shrink", 0, 1, 1, 0, 0, 4);
    for (int i = 0; i < 4; i++) applyStimulus("lim0up", 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("lim0dn", 0, 1, 0, 0, 0, 0);

    // Reset wins over load and ce, then hold with ce low.
    applyStimulus("ld5", 0, 0, 1, 1, 5, 9);
    applyStimulus("rstmid", 1, 1, 1, 1, 7, 9);
    for (int i = 0; i < 5; i++) applyStimulus("hold", 0, 0, 1, 0, 0, 9);

    // Randomised run over mixed limits, directions, loads and resets.
    for (int i = 0; i < 400; i++) begin
      logic r, c, u, l;
      int lv, lim;
      r   = ($urandom_range(0, 39) == 0);
      l   = ($urandom_range(0, 9) == 0);
      c   = ($urandom_range(0, 3) != 0);
      u   = 1'($urandom_range(0, 1));
      lv  = $urandom_range(0, 255);
      lim = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      applyStimulus("rand", r, c, u, l, lv, lim);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
